// File: rtl/mp_in.sv
// mp_in: upstream input packer for the AES-128 datapath.
// Collects 16 UART RX bytes (first byte lands in block[127:120]) into a 128-bit
// block. The block is then offered to the AES core as four 32-bit words, MSB word
// first, over a valid/ready handshake.
// An inter-byte timeout discards partial blocks. A sticky flag records bytes that
// arrive while a block is being unloaded.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous active-high reset
//   RX_DV_in      - one-cycle strobe, RX_byte_in valid
//   RX_byte_in    - received byte
//   core_ready_in - core accepts MP_word_out this cycle
//   ovf_clr_in    - clears MP_ovf_out (a same-cycle set wins)
//   MP_word_out   - current word to the core (0 when not sending)
//   MP_dv_out     - MP_word_out valid
//   MP_busy_out   - packer is not idle
//   MP_ovf_out    - sticky: a byte was dropped
module mp_in #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_DV_in,
    input  logic [7:0]            RX_byte_in,
    input  logic                  core_ready_in,
    input  logic                  ovf_clr_in,
    output logic [DATA_WIDTH-1:0] MP_word_out,
    output logic                  MP_dv_out,
    output logic                  MP_busy_out,
    output logic                  MP_ovf_out
);

    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        s_IDLE,
        s_RX_BYTES,
        s_SEND_WORDS,
        s_CLEANUP
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   block_q, block_d;
    logic [3:0]     byte_count_q, byte_count_d;
    logic [1:0]     word_idx_q, word_idx_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           ovf_q, ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= s_IDLE;
            block_q      <= '0;
            byte_count_q <= '0;
            word_idx_q   <= '0;
            to_cnt_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            block_q      <= block_d;
            byte_count_q <= byte_count_d;
            word_idx_q   <= word_idx_d;
            to_cnt_q     <= to_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        block_d      = block_q;
        byte_count_d = byte_count_q;
        word_idx_d   = word_idx_q;
        to_cnt_d     = to_cnt_q;

        unique case (state_q)
            s_IDLE: begin
                if (RX_DV_in) begin
                    block_d[127:120] = RX_byte_in;
                    byte_count_d     = 4'd1;
                    to_cnt_d         = '0;
                    state_d          = s_RX_BYTES;
                end
            end
            s_RX_BYTES: begin
                if (RX_DV_in) begin
                    // A byte on the timeout cycle wins over the timeout.
                    block_d[8*(4'd15 - byte_count_q) +: 8] = RX_byte_in;
                    to_cnt_d = '0;
                    if (byte_count_q == 4'd15) begin
                        byte_count_d = '0;
                        word_idx_d   = '0;
                        state_d      = s_SEND_WORDS;
                    end else begin
                        byte_count_d = byte_count_q + 4'd1;
                    end
                end else if (TIMEOUT_CYCLES != 0 && to_cnt_q == TO_LAST) begin
                    block_d      = '0;
                    byte_count_d = '0;
                    to_cnt_d     = '0;
                    state_d      = s_IDLE;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            s_SEND_WORDS: begin
                if (core_ready_in) begin
                    word_idx_d = word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) begin
                        state_d = s_CLEANUP;
                    end
                end
            end
            s_CLEANUP: begin
                block_d    = '0;
                word_idx_d = '0;
                state_d    = s_IDLE;
            end
            default: state_d = s_IDLE;
        endcase
    end

    // Bytes arriving while the block is unloaded are dropped; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        if (RX_DV_in && (state_q == s_SEND_WORDS || state_q == s_CLEANUP)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_in) begin
            ovf_d = 1'b0;
        end
    end

    logic [31:0] word_sel;

    always_comb begin
        word_sel = '0;
        if (state_q == s_SEND_WORDS) begin
            unique case (word_idx_q)
                2'd0: word_sel = block_q[127:96];
                2'd1: word_sel = block_q[95:64];
                2'd2: word_sel = block_q[63:32];
                2'd3: word_sel = block_q[31:0];
                default: word_sel = '0;
            endcase
        end
    end

    assign MP_word_out = DATA_WIDTH'(word_sel);
    assign MP_dv_out   = (state_q == s_SEND_WORDS);
    assign MP_busy_out = (state_q != s_IDLE);
    assign MP_ovf_out  = ovf_q;

endmodule

// File: tb/tb_mp_in.sv
// Self-checking bench for mp_in. A queue-based reference model predicts every
// output cycle by cycle under directed and randomized stimulus.
module tb_mp_in;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX_DV_in = 1'b0;
    logic [7:0]  RX_byte_in = '0;
    logic        core_ready_in = 1'b0;
    logic        ovf_clr_in = 1'b0;
    logic [31:0] MP_word_out;
    logic        MP_dv_out;
    logic        MP_busy_out;
    logic        MP_ovf_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mp_in #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_DV_in     (RX_DV_in),
        .RX_byte_in   (RX_byte_in),
        .core_ready_in(core_ready_in),
        .ovf_clr_in   (ovf_clr_in),
        .MP_word_out  (MP_word_out),
        .MP_dv_out    (MP_dv_out),
        .MP_busy_out  (MP_busy_out),
        .MP_ovf_out   (MP_ovf_out)
    );

    always #5 clk = ~clk;

    // Reference model: bytes being collected, words awaiting the core,
    // one cleanup cycle after the last word, idle-cycle counter, sticky flag.
    logic [7:0]  m_bytes[$];
    logic [31:0] m_words[$];
    bit          m_cleanup = 1'b0;
    int unsigned m_idle = 0;
    bit          m_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_bytes.delete();
        m_words.delete();
        m_cleanup = 1'b0;
        m_idle    = 0;
        m_ovf     = 1'b0;
    endfunction

    function automatic void model_update(input bit dv, input logic [7:0] b, input bit rdy,
                                         input bit clr);
        bit sending = (m_words.size() != 0);
        bit drop    = dv && (sending || m_cleanup);
        if (sending) begin
            if (rdy) begin
                m_words.delete(0);
                if (m_words.size() == 0) m_cleanup = 1'b1;
            end
        end else if (m_cleanup) begin
            m_cleanup = 1'b0;
        end else if (dv) begin
            m_bytes.push_back(b);
            m_idle = 0;
            if (m_bytes.size() == 16) begin
                for (int w = 0; w < 4; w++) begin
                    m_words.push_back({m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2],
                                       m_bytes[4*w+3]});
                end
                m_bytes.delete();
            end
        end else if (m_bytes.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_bytes.delete();
                m_idle = 0;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance.
    task automatic step(input bit dv, input logic [7:0] b, input bit rdy, input bit clr);
        logic [31:0] exp_word;
        bit exp_dv, exp_busy;
        @(negedge clk);
        exp_dv   = (m_words.size() != 0);
        exp_word = exp_dv ? m_words[0] : 32'h0;
        exp_busy = (m_bytes.size() != 0) || exp_dv || m_cleanup;
        check_eq("dv", {31'b0, MP_dv_out}, {31'b0, exp_dv});
        check_eq("word", MP_word_out, exp_word);
        check_eq("busy", {31'b0, MP_busy_out}, {31'b0, exp_busy});
        check_eq("ovf", {31'b0, MP_ovf_out}, {31'b0, m_ovf});
        RX_DV_in      = dv;
        RX_byte_in    = b;
        core_ready_in = rdy;
        ovf_clr_in    = clr;
        @(posedge clk);
        model_update(dv, b, rdy, clr);
        #1;
    endtask

    task automatic send_block(input logic [7:0] base, input bit gap, input bit rdy);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, base + 8'(i), rdy, 1'b0);
            if (gap && i < 15) step(1'b0, 8'h00, rdy, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {MP_word_out}, 32'h0);
        check_eq(tag, {28'b0, MP_dv_out, MP_busy_out, MP_ovf_out, 1'b0}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RX_DV_in = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("rst_high");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("after_rst");

        // 1: bytes 0x00..0x0F with gaps, ready held high
        send_block(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_word", MP_word_out, 32'h00010203 + 32'(i) * 32'h04040404);
            check_eq("t1_dv", {31'b0, MP_dv_out}, 32'd1);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("t1_busy_cleanup", {31'b0, MP_busy_out}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t1_busy_idle", {31'b0, MP_busy_out}, 32'd0);

        // 2: stall five cycles on word 1
        send_block(8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_hold", MP_word_out, 32'h04050607);
            check_eq("t2_hold_dv", {31'b0, MP_dv_out}, 32'd1);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_eq("t2_after", MP_word_out, 32'h04050607);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t2_w2", MP_word_out, 32'h08090A0B);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t2_w3", MP_word_out, 32'h0C0D0E0F);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // 3: timeout discards a 5-byte partial block after 8 idle cycles
        for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        repeat (7) step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_busy_7", {31'b0, MP_busy_out}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_busy_8", {31'b0, MP_busy_out}, 32'd0);
        check_eq("t3_ovf", {31'b0, MP_ovf_out}, 32'd0);
        send_block(8'hA0, 1'b0, 1'b1);
        check_eq("t3_first", MP_word_out, 32'hA0A1A2A3);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

        // 4: overflow set, set-beats-clear, lone clear
        send_block(8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("t4_ovf_set", {31'b0, MP_ovf_out}, 32'd1);
        check_eq("t4_word", MP_word_out, 32'h10111213);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check_eq("t4_set_wins", {31'b0, MP_ovf_out}, 32'd1);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t4_clr", {31'b0, MP_ovf_out}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // 5: reset after 9 bytes, then a clean block
        for (int i = 0; i < 9; i++) step(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0);
        do_reset();
        send_block(8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_word", MP_word_out, 32'hF0F1F2F3 + 32'(i) * 32'h04040404);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // 6: back-to-back blocks, second starts on the first idle cycle
        send_block(8'h20, 1'b0, 1'b1);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t6_idle", {31'b0, MP_busy_out}, 32'd0);
        send_block(8'h30, 1'b0, 1'b1);
        check_eq("t6_first", MP_word_out, 32'h30313233);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t6_ovf", {31'b0, MP_ovf_out}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 35), 8'($urandom), ($urandom_range(99) < 70),
                 ($urandom_range(99) < 5));
        end
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_in.md
Name: mp_in

Overview:
Upstream input packer for the AES-128 datapath. It collects 16 UART RX bytes into one 128-bit block, then presents that block to the AES core as four 32-bit words over a valid/ready handshake. Byte order is MSB-first: the first received byte is block[127:120]. Word order is MSB-first: word 0 is block[127:96]. It includes an inter-byte timeout that discards partial blocks, and a sticky overflow flag for bytes that arrive while the block is being unloaded.

Parameters:
DATA_WIDTH, 32, width of the core-side word; only 32 is supported (128/DATA_WIDTH = 4 words).
TIMEOUT_CYCLES, 1000000, number of idle clk cycles without RX_DV_in after which a partial block is discarded; 0 disables the timeout.

Ports:
clk  input  1  single system clock, all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
RX_DV_in  input  1  one-cycle strobe from the UART RX: RX_byte_in is valid.
RX_byte_in  input  8  received byte.
core_ready_in  input  1  AES core accepts MP_word_out this cycle.
ovf_clr_in  input  1  clears MP_ovf_out.
MP_word_out  output  DATA_WIDTH  current word to the core.
MP_dv_out  output  1  MP_word_out valid.
MP_busy_out  output  1  high whenever the state is not s_IDLE.
MP_ovf_out  output  1  sticky flag: a byte was dropped.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=s_IDLE; byte_count=0; word_idx=0; timeout counter=0; block register=0.
  - All outputs are 0 while rst is high and after reset.
  - Asserting rst mid-block or mid-send discards everything; no partial words are emitted afterwards.
- States: s_IDLE, s_RX_BYTES, s_SEND_WORDS, s_CLEANUP. The state is registered; outputs are decoded from registered state and counters only.
- s_IDLE:
  - On RX_DV_in: block[127:120]<=RX_byte_in, byte_count<=1, timeout<=0, go to s_RX_BYTES.
- s_RX_BYTES:
  - On RX_DV_in: block[127-8*byte_count -:8]<=RX_byte_in, byte_count<=byte_count+1, timeout<=0.
  - If byte_count==15 when RX_DV_in arrives, store the byte, set byte_count<=0 and word_idx<=0, and go to s_SEND_WORDS.
  - Cycles without RX_DV_in increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no RX_DV_in (and TIMEOUT_CYCLES!=0): clear the block and byte_count and go to s_IDLE. MP_ovf_out is not set.
  - If RX_DV_in arrives on that same cycle, the byte wins and the timeout is ignored.
- s_SEND_WORDS:
  - MP_dv_out=1 and MP_word_out=block[127-32*word_idx -:32].
  - A handshake occurs when MP_dv_out && core_ready_in; each handshake increments word_idx.
  - The handshake with word_idx==3 moves the state to s_CLEANUP.
  - While core_ready_in=0, MP_word_out and MP_dv_out hold stable.
- s_CLEANUP: lasts one cycle; block<=0, word_idx<=0, go to s_IDLE.
- Outside s_SEND_WORDS: MP_dv_out=0 and MP_word_out=0.
- Latency:
  - MP_dv_out rises on the first clk edge after the cycle carrying the 16th RX_DV_in.
  - With core_ready_in held at 1, the four words occupy 4 consecutive cycles.
  - The block is back in s_IDLE 2 cycles after the last handshake edge, i.e. ready for the next block's first byte.
- Overflow:
  - RX_DV_in in s_SEND_WORDS or s_CLEANUP drops the byte and sets MP_ovf_out<=1 on the next edge.
  - ovf_clr_in clears MP_ovf_out to 0.
  - If a set and ovf_clr_in occur in the same cycle, the set wins.
  - The flag has no effect on the data path.
- Width rules:
  - byte_count is 4 bits and never exceeds 15.
  - word_idx is 2 bits.
  - The timeout counter is sized $clog2(TIMEOUT_CYCLES+1) bits, minimum 1, and saturates; it never wraps.

Test Plan:
- Reset, then bytes 0x00..0x0F with one idle cycle between strobes and core_ready_in=1 -> MP_word_out is 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on 4 consecutive cycles with MP_dv_out=1; MP_busy_out drops 2 cycles after the last word.
- Same block, with core_ready_in=0 for 5 cycles at word_idx=1 -> 0x04050607 is held stable with MP_dv_out=1 for all 5 cycles; no word is skipped or duplicated.
- TIMEOUT_CYCLES=8: send 5 bytes then stop -> back in s_IDLE with MP_busy_out=0 after 8 idle cycles. Then send 0xA0..0xAF -> first word is 0xA0A1A2A3 (the partial block is discarded).
- RX_DV_in with 0x55 during s_SEND_WORDS -> MP_ovf_out=1 next cycle and the output words are unchanged. Pulse ovf_clr_in together with a new dropped byte -> MP_ovf_out stays 1. A lone ovf_clr_in -> MP_ovf_out=0.
- Assert rst after 9 bytes, release, then send a full block 0xF0..0xFF -> only 0xF0F1F2F3..0xFCFDFEFF is emitted. All outputs are 0 while rst is high.
- Two back-to-back blocks with the first byte of block 2 arriving in the first s_IDLE cycle -> both blocks are emitted correctly and MP_ovf_out stays 0.
